// File: rtl/holy_trace_buffer.sv
// holy_trace_buffer: NUM_CH x 32-bit debug trace FIFO with AXI-Lite readback.
// Optional start trigger (TRIG register, CTRL.ARMED) under `HOLY_TRACE_TRIGGER_EN.
module holy_trace_buffer #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_valid,
  input  logic [NUM_CH*32-1:0] cap_data,
  output logic                 irq_full,
  input  logic [ADDR_W-1:0]    s_axi_lite_awaddr,
  input  logic                 s_axi_lite_awvalid,
  output logic                 s_axi_lite_awready,
  input  logic [31:0]          s_axi_lite_wdata,
  input  logic [3:0]           s_axi_lite_wstrb,
  input  logic                 s_axi_lite_wvalid,
  output logic                 s_axi_lite_wready,
  output logic [1:0]           s_axi_lite_bresp,
  output logic                 s_axi_lite_bvalid,
  input  logic                 s_axi_lite_bready,
  input  logic [ADDR_W-1:0]    s_axi_lite_araddr,
  input  logic                 s_axi_lite_arvalid,
  output logic                 s_axi_lite_arready,
  output logic [31:0]          s_axi_lite_rdata,
  output logic [1:0]           s_axi_lite_rresp,
  output logic                 s_axi_lite_rvalid,
  input  logic                 s_axi_lite_rready
);
  localparam int PW = $clog2(DEPTH);

  logic [NUM_CH*32-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PW:0]          r_count;
  logic                 r_en, r_mode, r_ovf;
  logic                 r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]           r_bresp, r_rresp;
  logic [31:0]          r_rdata;

  logic [31:0]          w_aw_word, w_ar_word, w_rd_data;
  logic [NUM_CH*32-1:0] w_head;
  logic w_wr_hs, w_rd_hs, w_wr_ctrl, w_clr, w_pop, w_empty, w_full;
  logic w_cap, w_push, w_ovf, w_wr_mem, w_aw_ok, w_ar_ok, w_armed, w_trig_ok, w_unused;

  assign w_aw_word = 32'(s_axi_lite_awaddr >> 2);
  assign w_ar_word = 32'(s_axi_lite_araddr >> 2);
  assign w_wr_hs   = r_awready & s_axi_lite_awvalid & s_axi_lite_wvalid;
  assign w_rd_hs   = r_arready & s_axi_lite_arvalid;
  assign w_wr_ctrl = w_wr_hs & (w_aw_word == 32'd0);
  assign w_clr     = w_wr_ctrl & s_axi_lite_wdata[2];
  assign w_empty   = r_count == '0;
  assign w_full    = r_count == (PW+1)'(DEPTH);
  assign w_pop     = w_wr_hs & (w_aw_word == 32'd2) & !w_empty;
  assign w_cap     = cap_valid & r_en & w_trig_ok;
  // A pop on the same edge frees the slot, so a full buffer accepts the capture losslessly.
  assign w_push    = w_cap & (!w_full | w_pop);
  assign w_ovf     = w_cap & w_full & !w_pop;
  assign w_wr_mem  = w_push | (w_ovf & r_mode);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_unused  = ^{s_axi_lite_wstrb, s_axi_lite_wdata};

`ifdef HOLY_TRACE_TRIGGER_EN
  logic [31:0] r_trig;
  logic        r_armed;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (w_wr_hs && w_aw_word == 32'd3) r_trig <= s_axi_lite_wdata;
      if (w_wr_ctrl & s_axi_lite_wdata[0] & !r_en) r_armed <= 1'b1;
      else if (w_cap) r_armed <= 1'b0;
    end
  end
  assign w_armed   = r_armed;
  assign w_trig_ok = !r_armed | (cap_data[31:0] == r_trig);
  assign w_aw_ok   = (w_aw_word == 32'd0) | (w_aw_word == 32'd2) | (w_aw_word == 32'd3);
`else
  assign w_armed   = 1'b0;
  assign w_trig_ok = 1'b1;
  assign w_aw_ok   = (w_aw_word == 32'd0) | (w_aw_word == 32'd2);
`endif

  always_comb begin
    w_rd_data = '0;
    w_ar_ok   = 1'b0;
    if (w_ar_word == 32'd0) begin
      w_rd_data = {28'd0, w_armed, 1'b0, r_mode, r_en};
      w_ar_ok   = 1'b1;
    end
    if (w_ar_word == 32'd1) begin
      w_rd_data = {5'd0, 11'(r_count), 13'd0, r_ovf, w_full, w_empty};
      w_ar_ok   = 1'b1;
    end
`ifdef HOLY_TRACE_TRIGGER_EN
    if (w_ar_word == 32'd3) begin
      w_rd_data = r_trig;
      w_ar_ok   = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ar_word == 32'(4 + k)) begin
        w_rd_data = w_empty ? '0 : w_head[32*k +: 32];
        w_ar_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_mem) r_mem[r_wr_ptr] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (rst | w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_mem) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop | (w_ovf & r_mode)) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_mode <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= s_axi_lite_wdata[0];
      r_mode <= s_axi_lite_wdata[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_awready <= s_axi_lite_awvalid & s_axi_lite_wvalid & !r_bvalid & !r_awready;
      r_bvalid  <= w_wr_hs | (r_bvalid & !s_axi_lite_bready);
      if (w_wr_hs) r_bresp <= w_aw_ok ? 2'b00 : 2'b10;
      r_arready <= s_axi_lite_arvalid & !r_rvalid & !r_arready;
      r_rvalid  <= w_rd_hs | (r_rvalid & !s_axi_lite_rready);
      if (w_rd_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_ar_ok ? 2'b00 : 2'b10;
      end
    end
  end

  assign irq_full           = w_full;
  assign s_axi_lite_awready = r_awready;
  assign s_axi_lite_wready  = r_awready;
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_bvalid  = r_bvalid;
  assign s_axi_lite_arready = r_arready;
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;
  assign s_axi_lite_rvalid  = r_rvalid;
endmodule

// File: tb/tb_holy_trace_buffer.sv
// tb_holy_trace_buffer: queue-model scoreboard bench for holy_trace_buffer (DEPTH=4, NUM_CH=2).
module tb_holy_trace_buffer;
  localparam int NC = 2;
  localparam int DP = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           cap_valid = 1'b0;
  logic [NC*32-1:0] cap_data = '0;
  logic           irq_full;
  logic [AW-1:0]  awaddr = '0, araddr = '0;
  logic           awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic           bready = 1'b1, rready = 1'b1;
  logic [31:0]    wdata = '0;
  logic [3:0]     wstrb = 4'hF;
  logic           awready, wready, bvalid, arready, rvalid;
  logic [1:0]     bresp, rresp;
  logic [31:0]    rdata;

  holy_trace_buffer #(.NUM_CH(NC), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_data(cap_data), .irq_full(irq_full),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  int errors = 0;
  int checks = 0;
  logic [NC*32-1:0] mq[$];
  bit          m_en = 0, m_mode = 0, m_ovf = 0, m_armed = 0;
  logic [31:0] m_trig = '0;
  rexp_t       rq[$];
  logic [1:0]  bq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit wr_ok(input logic [7:0] a);
    int w = int'(a >> 2);
`ifdef HOLY_TRACE_TRIGGER_EN
    return w == 0 || w == 2 || w == 3;
`else
    return w == 0 || w == 2;
`endif
  endfunction

  function automatic rexp_t model_read(input logic [7:0] a);
    rexp_t r;
    int w = int'(a >> 2);
    logic [NC*32-1:0] e;
    r.resp = 2'b10;
    r.data = '0;
    if (w == 0) begin
      r.resp = 2'b00;
      r.data = {28'd0, m_armed, 1'b0, m_mode, m_en};
    end
    if (w == 1) begin
      r.resp = 2'b00;
      r.data = {5'd0, 11'(mq.size()), 13'd0, m_ovf, mq.size() == DP, mq.size() == 0};
    end
`ifdef HOLY_TRACE_TRIGGER_EN
    if (w == 3) begin
      r.resp = 2'b00;
      r.data = m_trig;
    end
`endif
    if (w >= 4 && w < 4 + NC) begin
      r.resp = 2'b00;
      if (mq.size() > 0) begin
        e = mq[0];
        r.data = 32'(e >> (32 * (w - 4)));
      end
    end
    return r;
  endfunction

  // One clock edge of the reference behaviour: optional register write plus optional capture.
  function automatic void model_edge(input bit wr, input logic [7:0] a, input logic [31:0] d,
                                     input bit cap, input logic [NC*32-1:0] cd);
    int w = int'(a >> 2);
    bit old_en = m_en;
    bit take;
    if (wr && w == 0 && d[2]) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (wr && w == 2 && mq.size() > 0) void'(mq.pop_front());
      if (cap && old_en) begin
        take = 1;
`ifdef HOLY_TRACE_TRIGGER_EN
        if (m_armed) begin
          take = (cd[31:0] == m_trig);
          if (take) m_armed = 0;
        end
`endif
        if (take) begin
          if (mq.size() < DP) mq.push_back(cd);
          else begin
            m_ovf = 1;
            if (m_mode) begin
              void'(mq.pop_front());
              mq.push_back(cd);
            end
          end
        end
      end
    end
    if (wr && w == 0) begin
`ifdef HOLY_TRACE_TRIGGER_EN
      if (d[0] && !old_en) m_armed = 1;
`endif
      m_en = d[0];
      m_mode = d[1];
    end
`ifdef HOLY_TRACE_TRIGGER_EN
    if (wr && w == 3) m_trig = d;
`endif
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input bit cap = 0, input logic [NC*32-1:0] cd = '0);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready=%b after %0d cycles, required 1", awready, n);
      awvalid = 0; wvalid = 0;
      return;
    end
    bq.push_back(wr_ok(a) ? 2'b00 : 2'b10);
    if (cap) begin cap_valid = 1; cap_data = cd; end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; cap_valid = 0;
    model_edge(1, a, d, cap, cd);
  endtask

  task automatic axi_read(input logic [7:0] a);
    int n = 0;
    araddr = a; arvalid = 1;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=%b after %0d cycles, required 1", arready, n);
      arvalid = 0;
      return;
    end
    rq.push_back(model_read(a));
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic cap(input logic [NC*32-1:0] cd);
    cap_valid = 1; cap_data = cd;
    @(posedge clk); #1;
    cap_valid = 0;
    model_edge(0, '0, '0, 1, cd);
  endtask

  task automatic chk_irq();
    @(negedge clk);
    chk("irq_full", 32'(irq_full), 32'(mq.size() == DP));
  endtask

  always @(negedge clk) begin
    rexp_t e;
    logic [1:0] be;
    if (!rst && bvalid) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL bvalid_unexpected: bvalid=1 required 0");
      end else begin
        be = bq.pop_front();
        chk("bresp", 32'(bresp), 32'(be));
      end
    end
    if (!rst && rvalid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: rvalid=1 required 0");
      end else begin
        e = rq.pop_front();
        chk("rresp", 32'(rresp), 32'(e.resp));
        if (e.resp == 2'b00) chk("rdata", rdata, e.data);
      end
    end
  end

  logic [7:0] rd_addrs [9] = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40, 8'hFC, 8'h11};

  initial begin
    int n;
    logic [31:0] d;
    logic [NC*32-1:0] cd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", 32'(irq_full), 0);
    @(posedge clk); #1;
    rst = 0;

    axi_read(8'h04);
    axi_read(8'h40);

    axi_write(8'h00, 32'h1);
    cap({32'hA0, 32'h100});
    cap({32'hA1, 32'h104});
    cap({32'hA2, 32'h108});
    axi_read(8'h04);
    axi_read(8'h10);
    axi_read(8'h14);
    axi_write(8'h08, 32'h0);
    axi_read(8'h10);

    axi_write(8'h00, 32'h5);
    for (int i = 0; i < 6; i++) cap({32'(i), 32'h300 + 32'(4 * i)});
    axi_read(8'h04);
    axi_read(8'h10);
    chk_irq();

    axi_write(8'h00, 32'h7);
    for (int i = 0; i < 6; i++) cap({32'h0, 32'(i)});
    axi_read(8'h04);
    axi_read(8'h10);

    axi_write(8'h00, 32'h5);
    for (int i = 0; i < 4; i++) cap({32'h0, 32'h500 + 32'(i)});
    axi_write(8'h08, 32'h0, 1, {32'h0, 32'h600});
    axi_read(8'h04);
    axi_read(8'h10);
    chk_irq();
    axi_write(8'h00, 32'h4);
    axi_read(8'h04);
    axi_read(8'h00);
    axi_write(8'h08, 32'h0);
    axi_read(8'h04);

`ifdef HOLY_TRACE_TRIGGER_EN
    axi_write(8'h0C, 32'h200);
    axi_write(8'h00, 32'h1);
    axi_read(8'h00);
    cap({32'h0, 32'h1F8});
    cap({32'h0, 32'h1FC});
    cap({32'h0, 32'h200});
    cap({32'h0, 32'h204});
    axi_read(8'h04);
    axi_read(8'h10);
    axi_read(8'h00);
    axi_read(8'h0C);
`endif

    for (int i = 0; i < 400; i++) begin
      cd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) cd[31:0] = m_trig;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cap(cd);
        4: begin
          d = $urandom;
          d[2] = ($urandom_range(0, 15) == 0);
          d[0] = ($urandom_range(0, 7) != 0);
          axi_write(8'h00, d);
        end
        5: axi_write(8'h08, $urandom, $urandom_range(0, 1) == 1, cd);
        6: axi_read(rd_addrs[$urandom_range(0, 8)]);
        7: axi_read(8'h04);
        8: axi_read(8'h10);
        default: axi_write($urandom_range(0, 1) == 1 ? 8'h40 : 8'h0C, $urandom);
      endcase
      chk_irq();
    end

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d reads and %0d writes outstanding, required 0", rq.size(), bq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/holy_trace_buffer.md
Name: holy_trace_buffer

Overview:
- Parametrised debug trace capture block for Holy Core. Successor to the fixed debug-out wiring at the core top level.
- Records NUM_CH 32-bit debug channels (e.g. pc, instruction, wb_data) into a DEPTH-entry on-chip FIFO on each cap_valid pulse.
- Software reads the buffer back through an AXI-Lite slave attached to the existing AXI-Lite interconnect.
- Has a stop-when-full mode and a ring-overwrite mode, plus a sticky overflow flag and a full interrupt.

Parameters:
- NUM_CH, 2, number of 32-bit capture channels per entry (1..8).
- DEPTH, 64, entries in the buffer; must be a power of 2, 2..1024.
- ADDR_W, 8, AXI-Lite address width used for decoding.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cap_valid  in  1  capture strobe; one entry per cycle while high.
- cap_data  in  NUM_CH*32  capture payload; channel k is bits [32k+31:32k].
- irq_full  out  1  high while count == DEPTH.
- s_axi_lite_awaddr  in  ADDR_W;  s_axi_lite_awvalid in 1;  s_axi_lite_awready out 1
- s_axi_lite_wdata  in  32;  s_axi_lite_wstrb in 4;  s_axi_lite_wvalid in 1;  s_axi_lite_wready out 1
- s_axi_lite_bresp  out  2;  s_axi_lite_bvalid out 1;  s_axi_lite_bready in 1
- s_axi_lite_araddr  in  ADDR_W;  s_axi_lite_arvalid in 1;  s_axi_lite_arready out 1
- s_axi_lite_rdata  out  32;  s_axi_lite_rresp out 2;  s_axi_lite_rvalid out 1;  s_axi_lite_rready in 1

Behaviour:
- Reset (rst high at a clock edge): pointers and count = 0; CTRL = 0; overflow = 0; all *ready, bvalid, rvalid = 0; bresp/rresp/rdata = 0; irq_full = 0. Reset mid-transaction drops any pending response.
- Register map (word aligned, addr[1:0] ignored):
  - 0x00 CTRL RW: bit0 EN; bit1 MODE (0 = stop when full, 1 = ring overwrite); bit2 CLR, write-1, self-clearing, reads 0.
  - 0x04 STATUS RO: bit0 empty; bit1 full; bit2 overflow (sticky); bits[26:16] count.
  - 0x08 POP WO: any write pops the head entry.
  - 0x10 + 4k DATA[k] RO: channel k of the head entry, for k < NUM_CH. Reads 0 when empty.
  - Any other offset returns SLVERR (2'b10); writes to it have no effect. Mapped accesses return OKAY.
- Write channel:
  - awready and wready assert together, for one cycle, only when awvalid & wvalid & !bvalid.
  - The register update happens on that handshake edge. bvalid rises the next cycle and holds until bready.
  - wstrb is ignored; full-word writes only.
- Read channel:
  - arready pulses when arvalid & !rvalid.
  - rdata/rresp are registered and rvalid rises the next cycle (1-cycle latency), holding until rready.
  - rdata is sampled at the arready edge.
- Capture happens on a clock edge where cap_valid & EN:
  - Not full: write at wr_ptr, wr_ptr++, count++.
  - Full, MODE=0: entry dropped, overflow set.
  - Full, MODE=1: oldest entry overwritten, wr_ptr++ and rd_ptr++, count unchanged, overflow set.
- Pop: rd_ptr++, count--. Pop when empty is ignored, returns OKAY, overflow unchanged.
- Capture and pop on the same edge: when not empty, both take effect and count is unchanged. When full, this is not overflow and nothing is lost. When empty, only the push applies.
- CLR on the same edge as a capture: CLR wins; pointers, count and overflow become 0 and the capture is discarded.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Storage is a DEPTH x NUM_CH*32 array with no reset (inferrable as RAM). Head data is read combinationally for the rdata register.

Optional Feature:
- Macro: HOLY_TRACE_TRIGGER_EN.
- Defined:
  - Adds register 0x0C TRIG RW (bits[31:0] match value) and CTRL bit3 ARMED (RO).
  - Setting EN arms the trigger, ARMED = 1. Captures are suppressed until a cap_valid cycle with cap_data[31:0] == TRIG.
  - That matching entry is captured and ARMED clears; capture then proceeds normally. Clearing EN re-arms on the next enable.
- Not defined: 0x0C returns SLVERR, CTRL bit3 reads 0, and capture starts as soon as EN is set.

Test Plan:
- Reset then read 0x04 -> rdata 0x00000001 (empty), OKAY; read 0x40 -> SLVERR.
- Write CTRL = 1, push 3 entries pc = 0x100, 0x104, 0x108 (NUM_CH = 2) -> STATUS count = 3. DATA[0] = 0x100; after a POP, DATA[0] = 0x104.
- MODE = 0, DEPTH = 4, push 6 -> count 4, full = 1, overflow = 1, irq_full = 1, head pc = first entry pushed.
- MODE = 1, DEPTH = 4, push pc 0..5 -> count 4, head pc = 2, overflow = 1.
- Full buffer with cap_valid and POP on the same edge -> count stays 4, overflow stays 0. Then CLR -> STATUS = 0x00000001.
- HOLY_TRACE_TRIGGER_EN defined, TRIG = 0x200: push 0x1F8, 0x1FC, 0x200, 0x204 -> count 2, head = 0x200, ARMED = 0.
